// File: rtl/dht11_ascii_fmt.sv
`default_nettype none
// ============================================================================
//  Module   : dht11_ascii_fmt
//  Purpose  : Captures a 40-bit DHT11 frame, verifies its checksum, converts
//             the integer humidity and temperature fields to two decimal
//             digits each, and streams an ASCII line into a TX FIFO:
//               OK  : "H=hh% T=ttC\r\n" (13 bytes)
//               ERR : "ERR\r\n"         (5 bytes, only when SEND_ERR != 0)
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous active-high reset
//             dht_data   - sensor frame {RH int, RH dec, T int, T dec, csum}
//             dht_valid  - one-cycle strobe qualifying dht_data
//             fifo_full  - TX FIFO full, blocks pushes
//             fifo_wdata - ASCII byte to the FIFO (holds when not pushing)
//             fifo_push  - one-cycle FIFO write strobe
//             busy       - frame in flight (capture .. last push)
//             csum_err   - one-cycle pulse on checksum failure
//             frame_drop - one-cycle pulse when a frame arrives while busy
//  Revision : 1.0 - initial release
// ============================================================================
module dht11_ascii_fmt #(
    parameter int SEND_ERR = 1,
    parameter int DEC_MAX  = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] dht_data,
    input  logic        dht_valid,
    input  logic        fifo_full,
    output logic [7:0]  fifo_wdata,
    output logic        fifo_push,
    output logic        busy,
    output logic        csum_err,
    output logic        frame_drop
);

    localparam logic [7:0] C_DEC_MAX = DEC_MAX[7:0];
    localparam logic [7:0] C_ASCII_0 = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CONV  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [39:0] r_data;
    logic [7:0]  r_h_rem;
    logic [7:0]  r_t_rem;
    logic [3:0]  r_h_tens;
    logic [3:0]  r_t_tens;
    logic [3:0]  r_idx;
    logic        r_err_msg;
    logic [7:0]  r_last_byte;

    logic [7:0]  w_sum;
    logic        w_csum_ok;
    logic        w_conv_done;
    logic [7:0]  w_h_clamp;
    logic [7:0]  w_t_clamp;
    logic [3:0]  w_last_idx;
    logic [7:0]  w_byte;
    logic        w_push;

    assign w_sum       = r_data[39:32] + r_data[31:24] + r_data[23:16] + r_data[15:8];
    assign w_csum_ok   = (w_sum == r_data[7:0]);
    assign w_conv_done = (r_h_rem < 8'd10) && (r_t_rem < 8'd10);
    assign w_h_clamp   = (r_data[39:32] > C_DEC_MAX) ? C_DEC_MAX : r_data[39:32];
    assign w_t_clamp   = (r_data[23:16] > C_DEC_MAX) ? C_DEC_MAX : r_data[23:16];
    assign w_last_idx  = r_err_msg ? 4'd4 : 4'd12;

    // Current message byte; ones digits are the remainders, already < 10.
    always_comb begin
        w_byte = 8'h00;
        if (r_err_msg) begin
            case (r_idx)
                4'd0:    w_byte = 8'h45;
                4'd1:    w_byte = 8'h52;
                4'd2:    w_byte = 8'h52;
                4'd3:    w_byte = 8'h0D;
                4'd4:    w_byte = 8'h0A;
                default: w_byte = 8'h00;
            endcase
        end else begin
            case (r_idx)
                4'd0:    w_byte = 8'h48;
                4'd1:    w_byte = 8'h3D;
                4'd2:    w_byte = C_ASCII_0 + {4'h0, r_h_tens};
                4'd3:    w_byte = C_ASCII_0 + {4'h0, r_h_rem[3:0]};
                4'd4:    w_byte = 8'h25;
                4'd5:    w_byte = 8'h20;
                4'd6:    w_byte = 8'h54;
                4'd7:    w_byte = 8'h3D;
                4'd8:    w_byte = C_ASCII_0 + {4'h0, r_t_tens};
                4'd9:    w_byte = C_ASCII_0 + {4'h0, r_t_rem[3:0]};
                4'd10:   w_byte = 8'h43;
                4'd11:   w_byte = 8'h0D;
                4'd12:   w_byte = 8'h0A;
                default: w_byte = 8'h00;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and strobes; the push strobe is gated by fifo_full in the
    // same cycle so it can never coincide with a full FIFO.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        csum_err    = 1'b0;
        busy        = (r_state != ST_IDLE);
        frame_drop  = dht_valid && (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (dht_valid) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_csum_ok) begin
                    w_state_nxt = ST_CONV;
                end else begin
                    csum_err    = 1'b1;
                    w_state_nxt = (SEND_ERR != 0) ? ST_SEND : ST_IDLE;
                end
            end
            ST_CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!fifo_full) begin
                    w_push = 1'b1;
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign fifo_push  = w_push;
    assign fifo_wdata = w_push ? w_byte : r_last_byte;

    // Datapath: capture, clamp, tens/ones by repeated subtraction, byte index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= 40'h0;
            r_h_rem     <= 8'h00;
            r_t_rem     <= 8'h00;
            r_h_tens    <= 4'h0;
            r_t_tens    <= 4'h0;
            r_idx       <= 4'h0;
            r_err_msg   <= 1'b0;
            r_last_byte <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dht_valid) begin
                        r_data <= dht_data;
                    end
                    r_idx <= 4'h0;
                end
                ST_CHECK: begin
                    r_h_rem   <= w_h_clamp;
                    r_t_rem   <= w_t_clamp;
                    r_h_tens  <= 4'h0;
                    r_t_tens  <= 4'h0;
                    r_err_msg <= !w_csum_ok;
                    r_idx     <= 4'h0;
                end
                ST_CONV: begin
                    if (r_h_rem >= 8'd10) begin
                        r_h_rem  <= r_h_rem - 8'd10;
                        r_h_tens <= r_h_tens + 4'd1;
                    end
                    if (r_t_rem >= 8'd10) begin
                        r_t_rem  <= r_t_rem - 8'd10;
                        r_t_tens <= r_t_tens + 4'd1;
                    end
                end
                ST_SEND: begin
                    if (w_push) begin
                        r_last_byte <= w_byte;
                        r_idx       <= r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dht11_ascii_fmt.md
DHT11_ASCII_FMT -- requirements
Module: dht11_ascii_fmt

Interface
REQ-001 The block SHALL have parameter SEND_ERR, default 1: 1 = emit "ERR\r\n" on checksum failure; 0 = emit nothing.
REQ-002 The block SHALL have parameter DEC_MAX, default 99: decimal clamp value for each displayed field.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port dht_data  input  40  sensor frame: [39:32] RH int, [31:24] RH dec, [23:16] T int, [15:8] T dec, [7:0] checksum.
REQ-006 The block SHALL have port dht_valid  input  1  one-cycle pulse; dht_data is valid in that cycle.
REQ-007 The block SHALL have port fifo_full  input  1  TX FIFO full; no push is permitted while high.
REQ-008 The block SHALL have port fifo_wdata  output  8  ASCII byte to the TX FIFO.
REQ-009 The block SHALL have port fifo_push  output  1  one-cycle write strobe, qualified with fifo_wdata.
REQ-010 The block SHALL have port busy  output  1  high from frame capture until the last byte is pushed.
REQ-011 The block SHALL have port csum_err  output  1  one-cycle pulse when a captured frame fails its checksum.
REQ-012 The block SHALL have port frame_drop  output  1  one-cycle pulse when dht_valid arrives while busy=1.

Function
REQ-013 States SHALL be IDLE, CHECK, CONV, SEND.
REQ-014 IDLE: on dht_valid=1, register dht_data, set busy=1 and go to CHECK; otherwise hold.
REQ-015 CHECK (1 cycle): checksum passes iff [7:0] == ([39:32]+[31:24]+[23:16]+[15:8]) mod 256.
REQ-016 CHECK on pass: go to CONV. CHECK on fail: pulse csum_err; go to SEND with the ERR message if SEND_ERR=1, else go to IDLE.
REQ-017 CONV: clamp RH int and T int to DEC_MAX.
REQ-018 CONV: derive tens/ones of both fields in parallel by repeated subtraction of 10, one subtraction per cycle.
REQ-019 CONV: ends when both remainders are < 10 (at most 10 cycles), then go to SEND.
REQ-020 OK message SHALL be 13 bytes: 'H' '=' Ht Ho '%' ' ' 'T' '=' Tt To 'C' 0x0D 0x0A, where digits are 0x30+value.
REQ-021 ERR message SHALL be 5 bytes: 'E' 'R' 'R' 0x0D 0x0A.
REQ-022 SEND: in each cycle with fifo_full=0, assert fifo_push=1 with the current byte and advance the byte index.
REQ-023 SEND: in each cycle with fifo_full=1, drive fifo_push=0 and hold the index (no byte skipped or repeated).
REQ-024 SEND: after the last byte is pushed, go to IDLE and set busy=0 in the following cycle.
REQ-025 Throughput SHALL be at most one push per cycle; fifo_push SHALL never be high while fifo_full is high in the same cycle.
REQ-026 dht_valid while busy=1 SHALL pulse frame_drop, be otherwise ignored, and leave the in-flight message unaltered.
REQ-027 dht_valid in the same cycle that busy returns to 0 (IDLE) SHALL be captured normally.
REQ-028 fifo_wdata SHALL hold its last value when fifo_push=0.
REQ-029 Latency, OK frame with FIFO never full: first push ≤ 13 cycles after dht_valid, last push ≤ 25 cycles after dht_valid.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, byte index 0, fifo_push=0, fifo_wdata=0x00, busy=0, csum_err=0, frame_drop=0.
REQ-031 Reset mid-message SHALL abandon the partial message; no further bytes are pushed after reset release without a new dht_valid.

Verification
REQ-032 dht_data=0x2D_00_17_00_44, dht_valid pulse, fifo_full=0 -> 13 pushes "H=45% T=23C\r\n", csum_err never high, busy low afterwards.
REQ-033 dht_data=0x12_34_56_78_9A, SEND_ERR=1 -> csum_err one pulse, 5 pushes "ERR\r\n"; with SEND_ERR=0 -> csum_err pulse, zero pushes.
REQ-034 dht_data=0x7D_00_05_00_82 (125 %RH, 5 C) -> "H=99% T=05C\r\n".
REQ-035 OK frame with fifo_full held high 4 cycles after the 3rd push -> fifo_push low during the stall, byte stream identical to REQ-032 with no gaps or duplicates.
REQ-036 Second dht_valid during SEND -> frame_drop one pulse, first message completes unchanged.
REQ-037 rst asserted after the 6th push -> fifo_push low the same cycle, no pushes after release; next valid frame yields a complete message.
